// File: rtl/cpu_pkg.sv
// Shared pipeline-stage definitions: opcodes, FSM state encoding and piece geometry.
package cpu_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP    = 4'd0;
    localparam opcode_t OP_LEFT   = 4'd1;
    localparam opcode_t OP_RIGHT  = 4'd2;
    localparam opcode_t OP_DOWN   = 4'd3;
    localparam opcode_t OP_ROTATE = 4'd4;
    localparam opcode_t OP_HALT   = 4'd5;

    localparam int CELLS = 4;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_CALC,
        ST_CHECK,
        ST_COMMIT,
        ST_ADVANCE,
        ST_HALT
    } state_t;

    // Opcodes that move the piece; everything else except HALT is a NOP.
    function automatic logic is_move(input opcode_t op);
        return (op >= OP_LEFT) && (op <= OP_ROTATE);
    endfunction

endpackage

// File: rtl/cell_check.sv
// Combinational collision test for one candidate cell against the board.
module cell_check
    import cpu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MEM_WIDTH = 4
) (
    input  logic [WIDTH-1:0]           x,
    input  logic [WIDTH-1:0]           y,
    input  logic [WIDTH*MEM_WIDTH-1:0] bus,
    output logic                       blocked
);

    logic [MEM_WIDTH-1:0][WIDTH-1:0] rows;
    logic                            hit;

    assign rows = bus;

    // Equality scan keeps out-of-range coordinates from ever indexing the board.
    always_comb begin
        hit = 1'b0;
        for (int r = 0; r < MEM_WIDTH; r++) begin
            for (int c = 0; c < WIDTH; c++) begin
                if (y == WIDTH'(r) && x == WIDTH'(c)) hit = rows[r][c];
            end
        end
    end

    assign blocked = (x >= WIDTH'(WIDTH)) || (y >= WIDTH'(MEM_WIDTH)) || hit;

endmodule

// File: rtl/cpu_step_2.sv
// Second pipeline stage: moves/rotates the falling piece, checks collisions cell by
// cell, and commits either the moved piece or a merged board back toward step 1.
module cpu_step_2
    import cpu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MEM_WIDTH  = 4,
    parameter int MEM_HEIGHT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2*WIDTH-1:0]         instr_step_1,
    input  logic [4*WIDTH-1:0]         coord_x_step_1,
    input  logic [4*WIDTH-1:0]         coord_y_step_1,
    input  logic [WIDTH*MEM_WIDTH-1:0] bus_step_1,
    output logic [4*WIDTH-1:0]         coord_x_step_2,
    output logic [4*WIDTH-1:0]         coord_y_step_2,
    output logic [WIDTH*MEM_WIDTH-1:0] bus_step_2,
    output logic                       is_load_PC,
    output logic                       is_write_reg,
    output logic                       is_touch,
    output logic                       busy
);

    state_t                          state;
    opcode_t                         op_q;
    logic [CELLS-1:0][WIDTH-1:0]     lat_x, lat_y;
    logic [CELLS-1:0][WIDTH-1:0]     cand_x, cand_y;
    logic [CELLS-1:0][WIDTH-1:0]     nx, ny;
    logic [MEM_WIDTH-1:0][WIDTH-1:0] bus_q, merged;
    logic [1:0]                      chk_idx;
    logic                            blocked, cur_blk, blk_all;

    logic unused_ok;
    assign unused_ok = ^{instr_step_1[2*WIDTH-5:0], 32'(MEM_HEIGHT)};

    // Candidate cells; ROTATE pivots every cell around cell 0.
    always_comb begin
        for (int i = 0; i < CELLS; i++) begin
            nx[i] = lat_x[i];
            ny[i] = lat_y[i];
            case (op_q)
                OP_LEFT:   nx[i] = lat_x[i] - WIDTH'(1);
                OP_RIGHT:  nx[i] = lat_x[i] + WIDTH'(1);
                OP_DOWN:   ny[i] = lat_y[i] + WIDTH'(1);
                OP_ROTATE: begin
                    nx[i] = lat_x[0] - (lat_y[i] - lat_y[0]);
                    ny[i] = lat_y[0] + (lat_x[i] - lat_x[0]);
                end
                default: ;
            endcase
        end
    end

    // Landed piece stamped into the board; out-of-bounds cells are dropped.
    always_comb begin
        merged = bus_q;
        for (int i = 0; i < CELLS; i++) begin
            for (int r = 0; r < MEM_WIDTH; r++) begin
                for (int c = 0; c < WIDTH; c++) begin
                    if (lat_x[i] == WIDTH'(c) && lat_y[i] == WIDTH'(r)) merged[r][c] = 1'b1;
                end
            end
        end
    end

    cell_check #(
        .WIDTH     (WIDTH),
        .MEM_WIDTH (MEM_WIDTH)
    ) u_cell_check (
        .x       (cand_x[chk_idx]),
        .y       (cand_y[chk_idx]),
        .bus     (bus_q),
        .blocked (cur_blk)
    );

    assign blk_all = blocked | cur_blk;

    // Status rather than a registered pulse: high straight out of reset (FETCH).
    assign busy = (state != ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_FETCH;
            op_q           <= OP_NOP;
            lat_x          <= '0;
            lat_y          <= '0;
            cand_x         <= '0;
            cand_y         <= '0;
            bus_q          <= '0;
            chk_idx        <= '0;
            blocked        <= 1'b0;
            coord_x_step_2 <= '0;
            coord_y_step_2 <= '0;
            bus_step_2     <= '0;
            is_load_PC     <= 1'b0;
            is_write_reg   <= 1'b0;
            is_touch       <= 1'b0;
        end else begin
            is_load_PC   <= 1'b0;
            is_write_reg <= 1'b0;
            is_touch     <= 1'b0;
            case (state)
                ST_FETCH: begin
                    op_q  <= instr_step_1[2*WIDTH-1 -: 4];
                    lat_x <= coord_x_step_1;
                    lat_y <= coord_y_step_1;
                    bus_q <= bus_step_1;
                    state <= ST_CALC;
                end
                ST_CALC: begin
                    if (op_q == OP_HALT) begin
                        state <= ST_HALT;
                    end else begin
                        cand_x  <= nx;
                        cand_y  <= ny;
                        chk_idx <= '0;
                        blocked <= 1'b0;
                        state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    blocked <= blk_all;
                    chk_idx <= chk_idx + 2'd1;
                    // Outputs are registered here so they are valid during COMMIT.
                    if (chk_idx == 2'd3) begin
                        state <= ST_COMMIT;
                        if (!blk_all && is_move(op_q)) begin
                            coord_x_step_2 <= cand_x;
                            coord_y_step_2 <= cand_y;
                            bus_step_2     <= bus_q;
                            is_write_reg   <= 1'b1;
                        end else if (blk_all && op_q == OP_DOWN) begin
                            coord_x_step_2 <= lat_x;
                            coord_y_step_2 <= lat_y;
                            bus_step_2     <= merged;
                            is_write_reg   <= 1'b1;
                            is_touch       <= 1'b1;
                        end else begin
                            coord_x_step_2 <= lat_x;
                            coord_y_step_2 <= lat_y;
                            bus_step_2     <= bus_q;
                        end
                    end
                end
                ST_COMMIT: begin
                    is_load_PC <= 1'b1;
                    state      <= ST_ADVANCE;
                end
                ST_ADVANCE: state <= ST_FETCH;
                ST_HALT:    state <= ST_HALT;
                default:    state <= ST_FETCH;
            endcase
        end
    end

endmodule
